// File: rtl/fc_argmax_out_pkg.sv
// Shared constants and state encoding for the FC arg-max output sink.
// Also used by the FC layer so score width and class count stay in step.
package fc_argmax_out_pkg;

    localparam int DWIDTH    = 16;
    localparam int NUM_CLASS = 10;
    localparam int IDX_W     = 4;
    localparam int CNT_W     = 16;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);
    localparam logic [IDX_W-1:0] NCLS     = IDX_W'(NUM_CLASS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_COLLECT = ST_COLLECT,
        S_HOLD    = ST_HOLD,
        S_DROP    = ST_DROP
    } state_t;

endpackage

// File: rtl/fc_argmax_out_score_buf.sv
// Score register file: one write port, combinational read port.
// Reads beyond the last class return zero.
module fc_score_buf
    import fc_argmax_out_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [NUM_CLASS];

    // Capture one score per write strobe; cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr < NCLS)) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range addresses read as zero.
    always_comb begin
        rdata = '0;
        if (raddr < NCLS) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/fc_argmax_out.sv
// FC class-score sink: buffers each frame, tracks the running arg-max,
// and hands the winner to the host through a valid/ready handshake.
module fc_argmax_out
    import fc_argmax_out_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_st,
    input  logic [DWIDTH-1:0] din,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [IDX_W-1:0]  result_class,
    output logic [DWIDTH-1:0] result_score,
    input  logic [IDX_W-1:0]  score_rd_addr,
    output logic [DWIDTH-1:0] score_rd_data,
    output logic [CNT_W-1:0]  frame_cnt,
    input  logic              err_clr,
    output logic              short_err,
    output logic              long_err,
    output logic              overrun_err
);

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [DWIDTH-1:0] max_q;
    logic [IDX_W-1:0]  idx_q;
    logic              first_hold;

    logic              hs;
    logic              gt;
    logic              is_last;
    logic              buf_we;
    logic [IDX_W-1:0]  buf_waddr;
    logic              short_ev;
    logic              long_ev;
    logic              ovr_ev;

    // Handshake, comparator and event decode for the current cycle.
    always_comb begin
        hs       = result_valid & result_ready;
        gt       = $signed(din) > $signed(max_q);
        is_last  = (cnt == LAST_IDX);
        short_ev = (state == S_COLLECT) & ~din_st;
        long_ev  = (state == S_HOLD) & first_hold & din_st;
        ovr_ev   = (state == S_HOLD) & ~first_hold & din_st
                 & ~result_ready;
        buf_we   = 1'b0;
        unique case (state)
            S_IDLE:    buf_we = din_st;
            S_COLLECT: buf_we = din_st;
            S_HOLD:    buf_we = din_st & hs & ~first_hold;
            S_DROP:    buf_we = 1'b0;
        endcase
        buf_waddr = (state == S_COLLECT) ? cnt : '0;
    end

    fc_score_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (din),
        .raddr (score_rd_addr),
        .rdata (score_rd_data)
    );

    // Frame FSM, running arg-max, registered result and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            max_q        <= '0;
            idx_q        <= '0;
            first_hold   <= 1'b0;
            result_valid <= 1'b0;
            result_class <= '0;
            result_score <= '0;
            frame_cnt    <= '0;
            short_err    <= 1'b0;
            long_err     <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            short_err   <= (short_err & ~err_clr) | short_ev;
            long_err    <= (long_err & ~err_clr) | long_ev;
            overrun_err <= (overrun_err & ~err_clr) | ovr_ev;

            if (hs) begin
                result_valid <= 1'b0;
                result_class <= '0;
                result_score <= '0;
                frame_cnt    <= frame_cnt + 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (din_st) begin
                        max_q <= din;
                        idx_q <= '0;
                        cnt   <= IDX_W'(1);
                        state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (din_st) begin
                        if (gt) begin
                            max_q <= din;
                            idx_q <= cnt;
                        end
                        cnt <= cnt + 1'b1;
                        if (is_last) begin
                            cnt          <= '0;
                            state        <= S_HOLD;
                            first_hold   <= 1'b1;
                            result_valid <= 1'b1;
                            result_class <= gt ? cnt : idx_q;
                            result_score <= gt ? din : max_q;
                        end
                    end else begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    first_hold <= 1'b0;
                    if (long_ev) begin
                        state <= S_DROP;
                    end else if (hs) begin
                        if (din_st) begin
                            max_q <= din;
                            idx_q <= '0;
                            cnt   <= IDX_W'(1);
                            state <= S_COLLECT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (din_st) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (!din_st) begin
                        state <= (result_valid & ~hs) ? S_HOLD : S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_argmax_out.sv
// Directed bench for fc_argmax_out: nominal, ties, backpressure,
// overrun, back-to-back, framing errors and mid-frame reset.
module tb_fc_argmax_out;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_st = 1'b0;
    logic [15:0] din = '0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [3:0]  result_class;
    logic [15:0] result_score;
    logic [3:0]  score_rd_addr = '0;
    logic [15:0] score_rd_data;
    logic [15:0] frame_cnt;
    logic        err_clr = 1'b0;
    logic        short_err;
    logic        long_err;
    logic        overrun_err;

    int total = 0;
    int bad = 0;

    logic [15:0] vec [12];

    fc_argmax_out dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din_st        (din_st),
        .din           (din),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_class  (result_class),
        .result_score  (result_score),
        .score_rd_addr (score_rd_addr),
        .score_rd_data (score_rd_data),
        .frame_cnt     (frame_cnt),
        .err_clr       (err_clr),
        .short_err     (short_err),
        .long_err      (long_err),
        .overrun_err   (overrun_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic load_nominal();
        vec = '{16'h0010, 16'hFFF0, 16'h0200, 16'h0004, 16'h0150,
                16'h0000, 16'h8000, 16'h01FF, 16'h0002, 16'h0003,
                16'h7FFF, 16'h7FFF};
    endtask

    task automatic load_tie2();
        vec = '{16'h0001, 16'h0020, 16'hFFFF, 16'h0100, 16'h00FF,
                16'h0000, 16'h8000, 16'h0100, 16'h0050, 16'h0010,
                16'h0000, 16'h0000};
    endtask

    // Drives n strobed samples at negedges; returns at the negedge
    // after the last sample, where din_st has just been dropped.
    task automatic send(input int n, input bit b2b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_st = 1'b1;
            din = vec[i];
            if (b2b) result_ready = (i == 0);
        end
        @(negedge clk);
        din_st = 1'b0;
        din = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (result_valid !== 1'b0 || result_class !== 4'd0 ||
            result_score !== 16'd0 || frame_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_result v=%b c=%0d s=%h f=%0d want 0",
                     result_valid, result_class, result_score, frame_cnt);
        end
        total++;
        if ({short_err, long_err, overrun_err} !== 3'b000 ||
            score_rd_data !== 16'd0) begin
            bad++;
            $display("FAIL reset_err errs=%b rd=%h want 000/0000",
                     {short_err, long_err, overrun_err}, score_rd_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        load_nominal();
        result_ready = 1'b1;
        send(10, 1'b0);
        total++;
        if (result_valid !== 1'b1 || result_class !== 4'd2 ||
            result_score !== 16'h0200) begin
            bad++;
            $display("FAIL nominal_result v=%b c=%0d s=%h want 1/2/0200",
                     result_valid, result_class, result_score);
        end
        @(negedge clk);
        total++;
        if (result_valid !== 1'b0 || frame_cnt !== 16'd1) begin
            bad++;
            $display("FAIL nominal_cnt v=%b f=%0d want 0/1",
                     result_valid, frame_cnt);
        end
        score_rd_addr = 4'd6;
        #1;
        total++;
        if (score_rd_data !== 16'h8000) begin
            bad++;
            $display("FAIL buf6 got=%h want=8000", score_rd_data);
        end
        score_rd_addr = 4'd12;
        #1;
        total++;
        if (score_rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL buf12 got=%h want=0000", score_rd_data);
        end
        score_rd_addr = 4'd0;
    endtask

    task automatic test_ties();
        for (int i = 0; i < 12; i++) vec[i] = 16'hFF80;
        send(10, 1'b0);
        total++;
        if (result_valid !== 1'b1 || result_class !== 4'd0 ||
            result_score !== 16'hFF80) begin
            bad++;
            $display("FAIL tie_all v=%b c=%0d s=%h want 1/0/FF80",
                     result_valid, result_class, result_score);
        end
        @(negedge clk);
        load_tie2();
        send(10, 1'b0);
        total++;
        if (result_valid !== 1'b1 || result_class !== 4'd3 ||
            result_score !== 16'h0100) begin
            bad++;
            $display("FAIL tie_3_7 v=%b c=%0d s=%h want 1/3/0100",
                     result_valid, result_class, result_score);
        end
        @(negedge clk);
        total++;
        if (frame_cnt !== 16'd3) begin
            bad++;
            $display("FAIL tie_cnt got=%0d want=3", frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        int unstable;
        unstable = 0;
        load_nominal();
        result_ready = 1'b0;
        send(10, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (result_valid !== 1'b1 || result_class !== 4'd2 ||
                result_score !== 16'h0200) unstable++;
            @(negedge clk);
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL bp_stable unstable_cycles=%0d want 0", unstable);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        total++;
        if (result_valid !== 1'b0 || frame_cnt !== 16'd4) begin
            bad++;
            $display("FAIL bp_release v=%b f=%0d want 0/4",
                     result_valid, frame_cnt);
        end
        repeat (2) @(negedge clk);
        total++;
        if (frame_cnt !== 16'd4) begin
            bad++;
            $display("FAIL bp_once got=%0d want=4", frame_cnt);
        end
    endtask

    task automatic test_overrun_b2b();
        load_nominal();
        result_ready = 1'b0;
        send(10, 1'b0);
        @(negedge clk);
        load_tie2();
        send(10, 1'b0);
        total++;
        if (overrun_err !== 1'b1 || result_valid !== 1'b1 ||
            result_class !== 4'd2 || result_score !== 16'h0200) begin
            bad++;
            $display("FAIL overrun o=%b v=%b c=%0d s=%h want 1/1/2/0200",
                     overrun_err, result_valid, result_class, result_score);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if ({short_err, long_err, overrun_err} !== 3'b000 ||
            result_valid !== 1'b1) begin
            bad++;
            $display("FAIL overrun_clr errs=%b v=%b want 000/1",
                     {short_err, long_err, overrun_err}, result_valid);
        end
        send(10, 1'b1);
        total++;
        if (result_valid !== 1'b1 || result_class !== 4'd3 ||
            result_score !== 16'h0100) begin
            bad++;
            $display("FAIL b2b_result v=%b c=%0d s=%h want 1/3/0100",
                     result_valid, result_class, result_score);
        end
        total++;
        if (overrun_err !== 1'b0 || frame_cnt !== 16'd5) begin
            bad++;
            $display("FAIL b2b_state o=%b f=%0d want 0/5",
                     overrun_err, frame_cnt);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        total++;
        if (result_valid !== 1'b0 || frame_cnt !== 16'd6) begin
            bad++;
            $display("FAIL b2b_hs v=%b f=%0d want 0/6",
                     result_valid, frame_cnt);
        end
    endtask

    task automatic test_framing();
        load_nominal();
        result_ready = 1'b1;
        send(6, 1'b0);
        @(negedge clk);
        total++;
        if (short_err !== 1'b1 || result_valid !== 1'b0) begin
            bad++;
            $display("FAIL short s=%b v=%b want 1/0", short_err, result_valid);
        end
        load_tie2();
        send(10, 1'b0);
        total++;
        if (result_valid !== 1'b1 || result_class !== 4'd3 ||
            result_score !== 16'h0100) begin
            bad++;
            $display("FAIL after_short v=%b c=%0d s=%h want 1/3/0100",
                     result_valid, result_class, result_score);
        end
        @(negedge clk);
        total++;
        if (frame_cnt !== 16'd7) begin
            bad++;
            $display("FAIL after_short_cnt got=%0d want=7", frame_cnt);
        end
        load_nominal();
        result_ready = 1'b0;
        send(12, 1'b0);
        total++;
        if (long_err !== 1'b1 || overrun_err !== 1'b0 ||
            result_valid !== 1'b1 || result_class !== 4'd2 ||
            result_score !== 16'h0200) begin
            bad++;
            $display("FAIL long l=%b o=%b v=%b c=%0d s=%h want 1/0/1/2/0200",
                     long_err, overrun_err, result_valid,
                     result_class, result_score);
        end
        @(negedge clk);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        total++;
        if (result_valid !== 1'b0 || frame_cnt !== 16'd8) begin
            bad++;
            $display("FAIL long_hs v=%b f=%0d want 0/8",
                     result_valid, frame_cnt);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if ({short_err, long_err, overrun_err} !== 3'b000) begin
            bad++;
            $display("FAIL err_clr got=%b want=000",
                     {short_err, long_err, overrun_err});
        end
        send(4, 1'b0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if (short_err !== 1'b1) begin
            bad++;
            $display("FAIL clr_vs_set got=%b want=1", short_err);
        end
    endtask

    task automatic test_reset_mid();
        load_nominal();
        result_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            din_st = 1'b1;
            din = vec[i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        din_st = 1'b0;
        din = '0;
        #1;
        total++;
        if (result_valid !== 1'b0 || frame_cnt !== 16'd0 ||
            {short_err, long_err, overrun_err} !== 3'b000 ||
            score_rd_data !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset v=%b f=%0d e=%b rd=%h want 0",
                     result_valid, frame_cnt,
                     {short_err, long_err, overrun_err}, score_rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(10, 1'b0);
        total++;
        if (result_valid !== 1'b1 || result_class !== 4'd2 ||
            result_score !== 16'h0200) begin
            bad++;
            $display("FAIL post_reset v=%b c=%0d s=%h want 1/2/0200",
                     result_valid, result_class, result_score);
        end
        @(negedge clk);
        total++;
        if (frame_cnt !== 16'd1 || short_err !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_cnt f=%0d s=%b want 1/0",
                     frame_cnt, short_err);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ties();
        test_backpressure();
        test_overrun_b2b();
        test_framing();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_argmax_out.md
Name: fc_argmax_out

Overview:
- Sink for the FC layer's class-score stream: 10 contiguous signed fixed-point scores, one per cycle, framed by a strobe.
- Captures each frame into a score buffer and computes the arg-max (predicted digit) on the fly.
- Presents the result to the host/AXI wrapper through a valid/ready handshake.
- Keeps a frame counter and sticky framing-error flags.

Parameters:
- DWIDTH, 16, score width (Q-format signed, matches FC output).
- NUM_CLASS, 10, scores per frame.
- IDX_W, 4, width of class index / buffer address.
- CNT_W, 16, width of frame counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; rst_n, asynchronous, active-low; clock clk.
- din_st  in  1  score strobe; high for exactly NUM_CLASS consecutive cycles per frame.
- din  in  DWIDTH  signed score, valid when din_st=1; class 0 first.
- result_valid  out  1  arg-max result available.
- result_ready  in  1  consumer accepts result.
- result_class  out  IDX_W  winning class index.
- result_score  out  DWIDTH  winning score (signed).
- score_rd_addr  in  IDX_W  buffer read address.
- score_rd_data  out  DWIDTH  buffered score, combinational read.
- frame_cnt  out  CNT_W  count of frames handed off (valid&ready), wraps.
- err_clr  in  1  clears sticky error flags.
- short_err  out  1  sticky: din_st fell before NUM_CLASS samples.
- long_err  out  1  sticky: din_st held beyond NUM_CLASS samples.
- overrun_err  out  1  sticky: frame arrived while a result was unconsumed.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State IDLE, sample counter 0, score buffer all 0.
- States: IDLE, COLLECT, HOLD, DROP.
- IDLE:
  - din_st=1: write din to buf[0]; max<=din; idx<=0; cnt<=1; go COLLECT.
- COLLECT:
  - din_st=1: write buf[cnt].
  - If din > max (signed, strictly greater): max<=din, idx<=cnt. Ties keep the lower index.
  - cnt increments. When the sample written has cnt==NUM_CLASS-1, go HOLD.
  - din_st=0 with cnt<NUM_CLASS: set short_err, discard partial frame (buffer contents undefined-but-stable), go IDLE. result_valid does not assert.
- HOLD:
  - result_valid=1, driving result_class=idx and result_score=max. Outputs are stable until the handshake.
  - Latency: last sample in cycle N; result_valid=1 in cycle N+1.
  - din_st=1 on the first HOLD cycle, i.e. the frame continues past NUM_CLASS: set long_err, go DROP. Result is kept (valid remains asserted in DROP).
  - valid&ready with din_st=0: result_valid=0 next cycle; frame_cnt++; go IDLE.
  - valid&ready with din_st=1 (new frame, same cycle): handshake completes, frame_cnt++, and din is captured as sample 0 of the new frame; go COLLECT.
  - din_st=1 with ready=0: set overrun_err; go DROP.
- DROP:
  - Ignores din until din_st=0.
  - result_valid stays asserted if still unconsumed; a handshake in DROP clears it and increments frame_cnt.
  - On din_st=0: go HOLD if the result is still pending, else IDLE.
- Buffer:
  - NUM_CLASS x DWIDTH registers, written only in IDLE/COLLECT capture cycles.
  - score_rd_data = buf[score_rd_addr], or 0 if addr >= NUM_CLASS.
  - In HOLD the buffer reflects the current result frame.
- Error flags:
  - err_clr clears all three next cycle.
  - A new error event in the same cycle as err_clr wins (flag is set).
- frame_cnt wraps from 2^CNT_W-1 to 0.
- Asynchronous reset mid-frame aborts everything to reset values. No partial result is ever emitted.

Decomposition:
- Shared package holds:
  - NUM_CLASS, DWIDTH, IDX_W constants (shared with the FC layer).
  - State encoding localparams.
- One natural sub-module: fc_score_buf, the NUM_CLASS-entry register file with a write enable/address and a combinational read port with out-of-range zero.
- FSM and arg-max comparator stay in the top module.

Test Plan:
- Nominal frame: scores {0x0010,0xFFF0,0x0200,0x0004,0x0150,0x0000,0x8000,0x01FF,0x0002,0x0003}, ready=1 -> result_valid 1 cycle after the 10th sample; class=2, score=0x0200; frame_cnt=1; buf[6] reads 0x8000; addr 12 reads 0.
- Ties and negatives: all ten scores 0xFF80 -> class=0, score=0xFF80. Scores equal 0x0100 at indices 3 and 7, others smaller -> class=3.
- Backpressure: hold ready=0 for 20 cycles after valid -> outputs are stable throughout; ready pulse -> valid low next cycle, frame_cnt increments exactly once.
- Overrun and back-to-back:
  - Second frame starts while ready=0 -> overrun_err=1, result unchanged (still the first frame).
  - Second frame starting in the same cycle as the handshake -> no error, and the second frame's arg-max is reported correctly.
- Framing errors:
  - 6-sample burst -> short_err=1, no valid, next full frame processed normally.
  - 12-sample burst -> long_err=1, result from the first 10 samples.
  - err_clr -> flags 0; err_clr coincident with a new short frame -> short_err stays 1.
- Reset mid-COLLECT (after 5 samples) -> all outputs 0, state IDLE; the following full frame yields the correct result with frame_cnt=1.
